// File: rtl/int_loader_pkg.sv
// Shared types and helpers for the intrinsic-message loader.
package int_loader_pkg;

   localparam int unsigned NUM_BANKS = 2;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FILL  = 2'd1,
      READY = 2'd2,
      BUSY  = 2'd3
   } bank_state_t;

   // Symmetric clamp of an in_width-bit LLR to +/-(2**(data_width-1)-1).
   function automatic logic signed [31:0] sat_llr(input logic signed [31:0] llr,
                                                  input int unsigned      in_width,
                                                  input int unsigned      data_width);
      logic signed [31:0] v;
      logic signed [31:0] lim;
      v   = (llr <<< (32 - in_width)) >>> (32 - in_width);
      lim = $signed(32'((1 << (data_width - 1)) - 1));
      if (v > lim) begin
         v = lim;
      end else if (v < -lim) begin
         v = -lim;
      end
      return v;
   endfunction

endpackage

// File: rtl/int_bank_ctrl.sv
// Per-bank lifecycle FSM plus the single-port mux between loader writes and decoder reads.
module int_bank_ctrl
   import int_loader_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_i,
   input  logic                  wr_last_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  start_i,
   input  logic                  done_i,
   input  logic                  dec_rd_en_i,
   input  logic [ADDR_WIDTH-1:0] dec_rd_addr_i,
   output bank_state_t           state_o,
   output logic [ADDR_WIDTH-1:0] ram_address_o,
   output logic [DATA_WIDTH-1:0] ram_data_in_o,
   output logic                  ram_we_o,
   output logic                  ram_cs_o
);

   bank_state_t           state_q, state_d;
   logic                  wr_q, last_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [DATA_WIDTH-1:0] data_q;
   logic                  busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         wr_q    <= 1'b0;
         last_q  <= 1'b0;
         addr_q  <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_i;
         last_q  <= wr_i & wr_last_i;
         if (wr_i) begin
            addr_q <= wr_addr_i;
            data_q <= wr_data_i;
         end
      end
   end

   // READY only once the final write has actually reached the RAM.
   always_comb begin
      state_d = state_q;
      case (state_q)
         EMPTY:   if (wr_i)            state_d = FILL;
         FILL:    if (wr_q && last_q)  state_d = READY;
         READY:   if (start_i)         state_d = BUSY;
         BUSY:    if (done_i)          state_d = EMPTY;
         default:                      state_d = EMPTY;
      endcase
   end

   assign busy          = (state_q == BUSY);
   assign state_o       = state_q;
   assign ram_cs_o      = busy ? dec_rd_en_i : wr_q;
   assign ram_we_o      = !busy && wr_q;
   assign ram_address_o = busy ? dec_rd_addr_i : addr_q;
   assign ram_data_in_o = data_q;

endmodule

// File: rtl/int_msg_loader.sv
// Ping-pong loader of saturated channel LLRs into two intrinsic-message RAM banks.
// Optional INT_LOADER_SAT_CNT_EN adds per-frame clamp counters (sat_cnt, sat_cnt_last).
module int_msg_loader
   import int_loader_pkg::*;
#(
   parameter int unsigned IN_WIDTH   = 8,
   parameter int unsigned DATA_WIDTH = 5,
   parameter int unsigned ADDR_WIDTH = 8,
   parameter int unsigned FRAME_LEN  = 256
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic signed [IN_WIDTH-1:0]   in_llr,
   input  logic                         in_valid,
   output logic                         in_ready,
   output logic                         frame_ready,
   output logic                         frame_bank,
   input  logic                         frame_start,
   input  logic                         frame_done,
   input  logic [ADDR_WIDTH-1:0]        dec_rd_addr,
   input  logic                         dec_rd_en,
   output logic [ADDR_WIDTH-1:0]        ram_address [0:NUM_BANKS-1],
   output logic [DATA_WIDTH-1:0]        ram_data_in [0:NUM_BANKS-1],
   output logic                         ram_we      [0:NUM_BANKS-1],
   output logic                         ram_cs      [0:NUM_BANKS-1],
   output logic                         proto_err
`ifdef INT_LOADER_SAT_CNT_EN
   ,
   output logic [15:0]                  sat_cnt,
   output logic [15:0]                  sat_cnt_last
`endif
);

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(FRAME_LEN - 1);

   if ((64'(FRAME_LEN) > (64'd1 << ADDR_WIDTH)) || (FRAME_LEN < 2)) begin : g_len_chk
      $error("int_msg_loader: FRAME_LEN must lie in [2, 2**ADDR_WIDTH]");
   end

   bank_state_t           state [NUM_BANKS];
   logic [ADDR_WIDTH-1:0] wr_cnt_q, wr_cnt_d;
   logic                  wr_bank_q, wr_bank_d;
   logic                  rd_bank_q, rd_bank_d;
   logic                  proto_err_q, proto_err_d;
   logic                  any_busy, accept, acc_last, start_ok, done_ok;
   logic [DATA_WIDTH-1:0] sat_data;

   assign sat_data    = DATA_WIDTH'(sat_llr(32'(in_llr), IN_WIDTH, DATA_WIDTH));
   assign any_busy    = (state[0] == BUSY) || (state[1] == BUSY);
   assign in_ready    = (state[wr_bank_q] == EMPTY) || (state[wr_bank_q] == FILL);
   assign frame_ready = (state[rd_bank_q] == READY) && !any_busy;
   assign frame_bank  = rd_bank_q;
   assign proto_err   = proto_err_q;
   assign accept      = in_valid && in_ready;
   assign acc_last    = (wr_cnt_q == LAST_ADDR);
   assign start_ok    = frame_start && frame_ready;
   assign done_ok     = frame_done && any_busy;

   always_comb begin
      wr_cnt_d    = wr_cnt_q;
      wr_bank_d   = wr_bank_q;
      rd_bank_d   = rd_bank_q;
      proto_err_d = proto_err_q;
      if (accept) begin
         wr_cnt_d = acc_last ? '0 : wr_cnt_q + ADDR_WIDTH'(1);
         if (acc_last) wr_bank_d = ~wr_bank_q;
      end
      // The busy bank is always rd_bank, so releasing it advances the read pointer.
      if (done_ok) rd_bank_d = ~rd_bank_q;
      if ((frame_start && !frame_ready) || (frame_done && !any_busy)) proto_err_d = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_cnt_q    <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         wr_cnt_q    <= wr_cnt_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         proto_err_q <= proto_err_d;
      end
   end

   for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
      int_bank_ctrl #(
         .DATA_WIDTH (DATA_WIDTH),
         .ADDR_WIDTH (ADDR_WIDTH)
      ) u_bank (
         .clk           (clk),
         .rst_n         (rst_n),
         .wr_i          (accept && (wr_bank_q == 1'(b))),
         .wr_last_i     (acc_last),
         .wr_addr_i     (wr_cnt_q),
         .wr_data_i     (sat_data),
         .start_i       (start_ok && (rd_bank_q == 1'(b))),
         .done_i        (frame_done && (state[b] == BUSY)),
         .dec_rd_en_i   (dec_rd_en),
         .dec_rd_addr_i (dec_rd_addr),
         .state_o       (state[b]),
         .ram_address_o (ram_address[b]),
         .ram_data_in_o (ram_data_in[b]),
         .ram_we_o      (ram_we[b]),
         .ram_cs_o      (ram_cs[b])
      );
   end

`ifdef INT_LOADER_SAT_CNT_EN
   logic        clamped;
   logic [15:0] sat_cnt_q, sat_cnt_d, sat_last_q, sat_last_d;

   assign clamped = (32'($signed(sat_data)) != 32'(in_llr));

   always_comb begin
      sat_cnt_d  = sat_cnt_q;
      sat_last_d = sat_last_q;
      if (accept) begin
         if (acc_last) begin
            sat_last_d = sat_cnt_q + 16'(clamped);
            sat_cnt_d  = '0;
         end else begin
            sat_cnt_d  = sat_cnt_q + 16'(clamped);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sat_cnt_q  <= '0;
         sat_last_q <= '0;
      end else begin
         sat_cnt_q  <= sat_cnt_d;
         sat_last_q <= sat_last_d;
      end
   end

   assign sat_cnt      = sat_cnt_q;
   assign sat_cnt_last = sat_last_q;
`endif

endmodule

// File: tb/tb_int_msg_loader.sv
// Bench for int_msg_loader: frame-count reference model, per-cycle compare, directed and random stimulus.
module tb_int_msg_loader;

   localparam int IW = 8;
   localparam int DW = 5;
   localparam int AW = 8;
   localparam int FL = 4;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic signed [IW-1:0] in_llr = '0;
   logic                 in_valid = 1'b0;
   logic                 in_ready;
   logic                 frame_ready;
   logic                 frame_bank;
   logic                 frame_start = 1'b0;
   logic                 frame_done = 1'b0;
   logic [AW-1:0]        dec_rd_addr = '0;
   logic                 dec_rd_en = 1'b0;
   logic [AW-1:0]        ram_address [0:1];
   logic [DW-1:0]        ram_data_in [0:1];
   logic                 ram_we      [0:1];
   logic                 ram_cs      [0:1];
   logic                 proto_err;
`ifdef INT_LOADER_SAT_CNT_EN
   logic [15:0]          sat_cnt;
   logic [15:0]          sat_cnt_last;
`endif

   int_msg_loader #(
      .IN_WIDTH   (IW),
      .DATA_WIDTH (DW),
      .ADDR_WIDTH (AW),
      .FRAME_LEN  (FL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_llr      (in_llr),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .frame_ready (frame_ready),
      .frame_bank  (frame_bank),
      .frame_start (frame_start),
      .frame_done  (frame_done),
      .dec_rd_addr (dec_rd_addr),
      .dec_rd_en   (dec_rd_en),
      .ram_address (ram_address),
      .ram_data_in (ram_data_in),
      .ram_we      (ram_we),
      .ram_cs      (ram_cs),
      .proto_err   (proto_err)
`ifdef INT_LOADER_SAT_CNT_EN
      ,
      .sat_cnt      (sat_cnt),
      .sat_cnt_last (sat_cnt_last)
`endif
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: frames are counted, not tracked as bank states.
   int k         = 0;   // samples accepted since reset
   int committed = 0;   // frames whose last write has reached the RAM
   int started   = 0;
   int released  = 0;
   bit cp        = 0;   // a frame's final write is in flight this cycle
   bit proto_m   = 0;
   bit pw_v      = 0;
   int pw_bank   = 0;
   int pw_addr   = 0;
   int pw_data   = 0;
   bit m_rdy, m_fr, m_bsy;

   function automatic int clamp(input int v);
      int lim;
      lim = (1 << (DW - 1)) - 1;
      if (v > lim) return lim;
      if (v < -lim) return -lim;
      return v;
   endfunction

   function bit m_busy();
      return started > released;
   endfunction

   function bit m_in_ready();
      return (k / FL - released) < 2;
   endfunction

   function bit m_frame_ready();
      return !m_busy() && (committed > started);
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         k = 0; committed = 0; started = 0; released = 0;
         cp = 0; proto_m = 0; pw_v = 0;
      end else begin
         m_rdy = m_in_ready();
         m_fr  = m_frame_ready();
         m_bsy = m_busy();
         if (cp) committed++;
         pw_v = in_valid && m_rdy;
         if (pw_v) begin
            pw_bank = (k / FL) % 2;
            pw_addr = k % FL;
            pw_data = clamp(int'(in_llr));
            k++;
         end
         cp = pw_v && (k % FL == 0);
         if (frame_start) begin
            if (m_fr) started++;
            else proto_m = 1;
         end
         if (frame_done) begin
            if (m_bsy) released++;
            else proto_m = 1;
         end
      end
   end

   // Every-cycle comparison of the DUT against the model.
   always @(negedge clk) begin
      if (rst_n) begin
         chk("in_ready", int'(in_ready), int'(m_in_ready()));
         chk("frame_ready", int'(frame_ready), int'(m_frame_ready()));
         chk("frame_bank", int'(frame_bank), released % 2);
         chk("proto_err", int'(proto_err), int'(proto_m));
         for (int b = 0; b < 2; b++) begin
            if (m_busy() && (b == released % 2)) begin
               chk($sformatf("rd ram_cs[%0d]", b), int'(ram_cs[b]), int'(dec_rd_en));
               chk($sformatf("rd ram_we[%0d]", b), int'(ram_we[b]), 0);
               if (dec_rd_en)
                  chk($sformatf("rd ram_address[%0d]", b), int'(ram_address[b]), int'(dec_rd_addr));
            end else if (pw_v && (pw_bank == b)) begin
               chk($sformatf("wr ram_cs[%0d]", b), int'(ram_cs[b]), 1);
               chk($sformatf("wr ram_we[%0d]", b), int'(ram_we[b]), 1);
               chk($sformatf("wr ram_address[%0d]", b), int'(ram_address[b]), pw_addr);
               chk($sformatf("wr ram_data_in[%0d]", b), int'($signed(ram_data_in[b])), pw_data);
            end else begin
               chk($sformatf("idle ram_cs[%0d]", b), int'(ram_cs[b]), 0);
               chk($sformatf("idle ram_we[%0d]", b), int'(ram_we[b]), 0);
            end
         end
      end
   end

   // Simple RAM image of everything the DUT writes.
   int log_mem [2][256];
   int wr_seen = 0;
   always @(negedge clk) begin
      for (int b = 0; b < 2; b++) begin
         if (ram_cs[b] && ram_we[b]) begin
            log_mem[b][ram_address[b]] = int'($signed(ram_data_in[b]));
            wr_seen++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      in_valid    = 1'b0;
      frame_start = 1'b0;
      frame_done  = 1'b0;
      dec_rd_en   = 1'b0;
   endtask

   task automatic do_reset();
      idle_in();
      rst_n = 1'b0;
      #1;
      chk("rst in_ready", int'(in_ready), 1);
      chk("rst frame_ready", int'(frame_ready), 0);
      chk("rst frame_bank", int'(frame_bank), 0);
      chk("rst proto_err", int'(proto_err), 0);
      for (int b = 0; b < 2; b++) begin
         chk("rst ram_we", int'(ram_we[b]), 0);
         chk("rst ram_cs", int'(ram_cs[b]), 0);
         chk("rst ram_address", int'(ram_address[b]), 0);
         chk("rst ram_data_in", int'(ram_data_in[b]), 0);
      end
      step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic feed(input int n);
      for (int i = 0; i < n; i++) begin
         in_valid = 1'b1;
         in_llr   = IW'($urandom);
         step();
      end
      in_valid = 1'b0;
   endtask

   int vals [4] = '{3, -3, 100, -128};
   int base;

   initial begin
      for (int b = 0; b < 2; b++)
         for (int a = 0; a < 256; a++) log_mem[b][a] = -99;

      // Single frame with saturation boundaries.
      do_reset();
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1;
         in_llr   = IW'(vals[i]);
         step();
      end
      in_valid = 1'b0;
      chk("s1 frame_ready t+1", int'(frame_ready), 0);
      step();
      chk("s1 frame_ready t+2", int'(frame_ready), 1);
      chk("s1 frame_bank", int'(frame_bank), 0);
      chk("s1 mem0[0]", log_mem[0][0], 3);
      chk("s1 mem0[1]", log_mem[0][1], -3);
      chk("s1 mem0[2]", log_mem[0][2], 15);
      chk("s1 mem0[3]", log_mem[0][3], -15);

      // Both banks fill, further samples stall.
      do_reset();
      base = wr_seen;
      feed(16);
      step();
      chk("s2 writes", wr_seen - base, 8);
      chk("s2 in_ready", int'(in_ready), 0);
      chk("s2 frame_ready", int'(frame_ready), 1);

      // Decoder takes bank 0 and reads through it.
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      dec_rd_en   = 1'b1;
      dec_rd_addr = AW'(2);
      #1;
      chk("s3 ram_cs0", int'(ram_cs[0]), 1);
      chk("s3 ram_we0", int'(ram_we[0]), 0);
      chk("s3 ram_address0", int'(ram_address[0]), 2);
      chk("s3 ram_cs1", int'(ram_cs[1]), 0);
      step();
      dec_rd_en  = 1'b0;
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      #1;
      chk("s3 in_ready", int'(in_ready), 1);
      chk("s3 frame_bank", int'(frame_bank), 1);
      chk("s3 frame_ready", int'(frame_ready), 1);

      // Reset mid-frame discards the partial frame.
      do_reset();
      feed(2);
      rst_n = 1'b0;
      #1;
      chk("s4 ram_we0", int'(ram_we[0]), 0);
      chk("s4 ram_we1", int'(ram_we[1]), 0);
      chk("s4 frame_ready", int'(frame_ready), 0);
      step();
      rst_n = 1'b1;
      step();
      in_valid = 1'b1;
      in_llr   = IW'(7);
      step();
      in_valid = 1'b0;
      #1;
      chk("s4 ram_we0 after", int'(ram_we[0]), 1);
      chk("s4 ram_address0", int'(ram_address[0]), 0);
      chk("s4 ram_data0", int'($signed(ram_data_in[0])), 7);

      // Protocol violations.
      do_reset();
      frame_done = 1'b1;
      step();
      frame_done = 1'b0;
      chk("s5 proto_err done", int'(proto_err), 1);
      chk("s5 in_ready", int'(in_ready), 1);
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      step();
      chk("s5 proto_err sticky", int'(proto_err), 1);
      chk("s5 frame_ready", int'(frame_ready), 0);

      // frame_done for bank 0 coincides with the last accept into bank 1.
      do_reset();
      feed(4);
      step();
      frame_start = 1'b1;
      step();
      frame_start = 1'b0;
      feed(3);
      in_valid   = 1'b1;
      in_llr     = IW'(-20);
      frame_done = 1'b1;
      step();
      idle_in();
      #1;
      chk("s6 frame_ready t+1", int'(frame_ready), 0);
      chk("s6 in_ready", int'(in_ready), 1);
      step();
      chk("s6 frame_ready t+2", int'(frame_ready), 1);
      chk("s6 frame_bank", int'(frame_bank), 1);
      chk("s6 mem1[3]", log_mem[1][3], -15);

      // Randomized traffic with a legal decoder and one mid-run reset.
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         if (n == 1500) begin
            do_reset();
         end
         in_valid    = ($urandom % 10) < 7;
         in_llr      = IW'($urandom);
         frame_start = m_frame_ready() && (($urandom % 3) == 0);
         frame_done  = m_busy() && (($urandom % 5) == 0);
         dec_rd_en   = $urandom % 2;
         dec_rd_addr = AW'($urandom);
         step();
      end
      idle_in();
      step();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
